// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in/serial-out stage with one-word holding buffer
//
// Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one
// bit per clock. A holding register lets the next word wait while the current
// one shifts, so back-to-back words form a gap-free bit stream.
//
// Ports:
//   clk_i         clock, all state updates on the rising edge
//   rst_ni        asynchronous active-low reset
//   din_i         parallel input word
//   din_valid_i   din_i holds a word
//   din_ready_o   holding register empty; accept on din_valid_i && din_ready_o
//   out_o         serial bit (IDLE_BIT when nothing is shifting)
//   out_valid_o   out_o carries a data bit
//   word_done_o   out_o carries the last bit of a word
//   busy_o        shifting, or holding register full
module piso_serializer #(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] din_i,
  input  logic             din_valid_i,
  output logic             din_ready_o,
  output logic             out_o,
  output logic             out_valid_o,
  output logic             word_done_o,
  output logic             busy_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    bitcnt_q, bitcnt_d;

  logic accept;
  logic out_bit;

  assign din_ready_o = !hold_full_q;
  assign accept      = din_valid_i && !hold_full_q;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    sreg_d      = sreg_q;
    bitcnt_d    = bitcnt_q;

    // An accept can never coincide with a reload: both need opposite values
    // of hold_full_q, so the reload below never overwrites a fresh accept.
    if (accept) begin
      hold_d      = din_i;
      hold_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          sreg_d      = hold_q;
          hold_full_d = 1'b0;
          bitcnt_d    = '0;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (MSB_FIRST) begin
          sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
        end else begin
          sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
        end
        bitcnt_d = bitcnt_q + CW'(1);
        if (bitcnt_q == LAST) begin
          bitcnt_d = '0;
          if (hold_full_q) begin
            // Reload straight from the buffer so no idle bit is inserted.
            sreg_d      = hold_q;
            hold_full_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      sreg_q      <= '0;
      bitcnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      sreg_q      <= sreg_d;
      bitcnt_q    <= bitcnt_d;
    end
  end

  // Outputs decode registered state only, so reset clears them immediately.
  assign out_bit     = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
  assign out_valid_o = (state_q == SHIFT);
  assign out_o       = out_valid_o ? out_bit : IDLE_BIT;
  assign word_done_o = (state_q == SHIFT) && (bitcnt_q == LAST);
  assign busy_o      = (state_q == SHIFT) || hold_full_q;

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - self-checking bench for piso_serializer
module tb_piso_serializer;

  typedef struct packed {
    logic [7:0] word;
    logic [7:0] seq;   // expected serial order, seq[7] leaves first
  } vec_t;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [7:0] m_din = '0;
  logic       m_valid = 1'b0;
  logic       m_ready, m_out, m_out_valid, m_word_done, m_busy;

  logic [7:0] l_din = '0;
  logic       l_valid = 1'b0;
  logic       l_ready, l_out, l_out_valid, l_word_done, l_busy;

  int n_cmp = 0;
  int n_fail = 0;
  int m_wd_cnt = 0;
  int l_wd_cnt = 0;
  int m_run = 0;
  int m_max_run = 0;
  int last_wait = 0;
  bit mon_en = 1'b0;

  exp_t mq[$];
  exp_t lq[$];

  vec_t mtab[8];
  vec_t ltab[3];

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .din_i(m_din), .din_valid_i(m_valid),
    .din_ready_o(m_ready), .out_o(m_out), .out_valid_o(m_out_valid),
    .word_done_o(m_word_done), .busy_o(m_busy)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
    .clk_i(clk), .rst_ni(rst_n), .din_i(l_din), .din_valid_i(l_valid),
    .din_ready_o(l_ready), .out_o(l_out), .out_valid_o(l_out_valid),
    .word_done_o(l_word_done), .busy_o(l_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output monitor: pops expected bits whenever a serializer presents data.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      if (m_out_valid) begin
        m_run++;
        if (m_run > m_max_run) m_max_run = m_run;
        if (m_word_done) m_wd_cnt++;
        if (mq.size() == 0) check("m_unexpected_bit", 1, 0);
        else begin
          e = mq.pop_front();
          check("m_out", m_out, e.b);
          check("m_word_done", m_word_done, e.last);
        end
      end else begin
        m_run = 0;
        check("m_idle_out", m_out, 0);
        check("m_idle_word_done", m_word_done, 0);
      end
      if (l_out_valid) begin
        if (l_word_done) l_wd_cnt++;
        if (lq.size() == 0) check("l_unexpected_bit", 1, 0);
        else begin
          e = lq.pop_front();
          check("l_out", l_out, e.b);
          check("l_word_done", l_word_done, e.last);
        end
      end else begin
        check("l_idle_out", l_out, 0);
      end
    end
  end

  // Called just after a falling edge; returns one falling edge after the accept.
  task automatic send(input bit lsb, input vec_t v);
    int n;
    n = 0;
    if (lsb) begin l_din = v.word; l_valid = 1'b1; end
    else begin m_din = v.word; m_valid = 1'b1; end
    while (((lsb && !l_ready) || (!lsb && !m_ready)) && n < 64) begin
      @(negedge clk);
      n++;
    end
    last_wait = n;
    if (n >= 64) check("send_timeout", 1, 0);
    else begin
      for (int i = 7; i >= 0; i--) begin
        if (lsb) lq.push_back('{b: v.seq[i], last: (i == 0)});
        else mq.push_back('{b: v.seq[i], last: (i == 0)});
      end
    end
    @(negedge clk);
    if (lsb) l_valid = 1'b0;
    else m_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((mq.size() != 0 || lq.size() != 0 || m_busy || l_busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("drain_timeout", 1, 0);
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_out"}, m_out, 0);
    check({tag, "_out_valid"}, m_out_valid, 0);
    check({tag, "_din_ready"}, m_ready, 1);
    check({tag, "_busy"}, m_busy, 0);
    check({tag, "_word_done"}, m_word_done, 0);
  endtask

  initial begin
    int wd0;
    mtab[0] = '{word: 8'hA5, seq: 8'hA5};
    mtab[1] = '{word: 8'h3C, seq: 8'h3C};
    mtab[2] = '{word: 8'h11, seq: 8'h11};
    mtab[3] = '{word: 8'h22, seq: 8'h22};
    mtab[4] = '{word: 8'h33, seq: 8'h33};
    mtab[5] = '{word: 8'hFF, seq: 8'hFF};
    mtab[6] = '{word: 8'h0F, seq: 8'h0F};
    mtab[7] = '{word: 8'h81, seq: 8'h81};
    ltab[0] = '{word: 8'h01, seq: 8'h80};
    ltab[1] = '{word: 8'h12, seq: 8'h48};
    ltab[2] = '{word: 8'hC1, seq: 8'h83};

    // Reset state, then quiet period after release.
    repeat (3) @(negedge clk);
    check_idle("reset");
    check("reset_l_ready", l_ready, 1);
    mon_en = 1'b1;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_idle("post_reset");

    // Isolated words from both tables.
    for (int i = 0; i < 2; i++) begin
      send(1'b0, mtab[i]);
      drain();
    end
    for (int i = 0; i < 3; i++) begin
      send(1'b1, ltab[i]);
      drain();
    end
    check("single_m_words", m_wd_cnt, 2);
    check("single_l_words", l_wd_cnt, 3);

    // Back-to-back: 16 contiguous data bits, ready low between accepts.
    m_max_run = 0;
    send(1'b0, mtab[0]);
    send(1'b0, mtab[1]);
    check("b2b_ready_stall", (last_wait >= 1), 1);
    drain();
    check("b2b_run_length", m_max_run, 16);
    check("b2b_words", m_wd_cnt, 4);

    // Back-pressure: three words offered continuously.
    m_max_run = 0;
    send(1'b0, mtab[2]);
    send(1'b0, mtab[3]);
    send(1'b0, mtab[4]);
    check("bp_third_stalled", (last_wait >= 1), 1);
    drain();
    check("bp_run_length", m_max_run, 24);
    check("bp_words", m_wd_cnt, 7);

    // Reset mid-word with a second word buffered.
    send(1'b0, mtab[5]);
    send(1'b0, mtab[6]);
    repeat (2) @(negedge clk);
    check("pre_rst_valid", m_out_valid, 1);
    check("pre_rst_busy", m_busy, 1);
    rst_n = 1'b0;
    #1;
    check_idle("mid_rst");
    mq.delete();
    lq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wd0 = m_wd_cnt;
    repeat (12) @(negedge clk);
    check("no_stale_words", m_wd_cnt, wd0);
    check_idle("after_rst");
    send(1'b0, mtab[7]);
    drain();
    check("fresh_word_done", m_wd_cnt, wd0 + 1);
    check("final_queue_empty", mq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
